// File: rtl/tdc_tx_framer.sv
// tdc_tx_framer
//   Frames 24-bit TDC words into a byte stream for an 8b10b encoder.
//   After reset a run of SYNC_LEN comma characters is sent. After that the
//   link idles on commas and sends each queued word as three data bytes,
//   most significant byte first. A comma is forced after at most KEEPALIVE
//   back-to-back words so the receiver keeps its alignment.
//
// Ports
//   WCLK       in   1   byte clock (sole clock)
//   RESET      in   1   synchronous, active-high reset
//   enable     in   1   allow data transmission (0: commas only)
//   data_in    in  24   TDC word
//   data_valid in   1   data_in valid
//   data_ready out  1   input FIFO can accept a word this cycle
//   tx_byte    out  8   byte to the encoder
//   tx_k       out  1   tx_byte is a control character
//   sync_done  out  1   initial comma run finished
//   word_cnt   out 16   words transmitted (saturating)
//   lost_cnt   out  8   words offered while not ready (saturating)
module tdc_tx_framer #(
  parameter int          SYNC_LEN  = 32,
  parameter int          KEEPALIVE = 16,
  parameter logic [7:0]  COMMA     = 8'hBC,
  parameter int          ASIZE     = 2
) (
  input  logic        WCLK,
  input  logic        RESET,
  input  logic        enable,
  input  logic [23:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_k,
  output logic        sync_done,
  output logic [15:0] word_cnt,
  output logic [7:0]  lost_cnt
);

  localparam int DATA_W = 24;
  localparam int DEPTH  = 2**ASIZE;
  localparam int SW     = $clog2(SYNC_LEN + 1);
  localparam int RW     = $clog2(KEEPALIVE + 1);

  typedef enum logic [2:0] {SYNC, IDLE, B0, B1, B2} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ASIZE:0]    wptr, rptr;
  logic [ASIZE:0]    occ, occ_next;
  logic              empty, push, pop, can_send;
  logic [DATA_W-1:0] word_p0;
  logic [SW-1:0]     sync_cnt;
  logic [RW-1:0]     run_cnt, run_next;

  // Pointers carry one extra bit so full (difference DEPTH) and empty
  // (difference 0) are distinguishable; the difference is the occupancy.
  assign occ      = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign push     = data_valid & data_ready;
  assign can_send = !empty && enable;
  assign run_next = run_cnt + 1'b1;

  // A word is popped either leaving IDLE or chaining straight from B2; the
  // chained case stops once the run reaches KEEPALIVE so a comma goes out.
  always_comb begin
    pop = 1'b0;
    if (state == IDLE)
      pop = can_send;
    else if (state == B2)
      pop = can_send && (run_next < RW'(KEEPALIVE));
  end

  assign occ_next = occ + {{ASIZE{1'b0}}, push} - {{ASIZE{1'b0}}, pop};

  // FIFO storage and the word being serialised carry no reset: pointers
  // and state decide whether their contents are ever used.
  always_ff @(posedge WCLK) begin
    if (push)
      mem[wptr[ASIZE-1:0]] <= data_in;
    if (pop)
      word_p0 <= mem[rptr[ASIZE-1:0]];
  end

  // Control FSM and registered outputs. tx_byte is the byte emitted by the
  // state that was current before the edge, so a pop on leaving IDLE puts
  // the first data byte out one edge later.
  always_ff @(posedge WCLK) begin
    if (RESET) begin
      state      <= SYNC;
      tx_byte    <= COMMA;
      tx_k       <= 1'b1;
      sync_done  <= 1'b0;
      data_ready <= 1'b0;
      word_cnt   <= '0;
      lost_cnt   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      sync_cnt   <= '0;
      run_cnt    <= '0;
    end else begin
      data_ready <= (occ_next < (ASIZE+1)'(DEPTH));
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (data_valid && !data_ready)
        lost_cnt <= sat_inc8(lost_cnt);

      case (state)
        SYNC: begin
          tx_byte <= COMMA;
          tx_k    <= 1'b1;
          if (sync_cnt == SW'(SYNC_LEN - 1)) begin
            state     <= IDLE;
            sync_done <= 1'b1;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        IDLE: begin
          tx_byte <= COMMA;
          tx_k    <= 1'b1;
          run_cnt <= '0;
          if (can_send)
            state <= B0;
        end
        B0: begin
          tx_byte <= word_p0[23:16];
          tx_k    <= 1'b0;
          state   <= B1;
        end
        B1: begin
          tx_byte <= word_p0[15:8];
          tx_k    <= 1'b0;
          state   <= B2;
        end
        B2: begin
          tx_byte  <= word_p0[7:0];
          tx_k     <= 1'b0;
          word_cnt <= sat_inc16(word_cnt);
          if (pop) begin
            run_cnt <= run_next;
            state   <= B0;
          end else begin
            run_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          tx_byte <= COMMA;
          tx_k    <= 1'b1;
          state   <= SYNC;
        end
      endcase
    end
  end

endmodule
